// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared CPU types and constants
package mycpu_pkg;

   localparam int WIDTH      = 16;
   localparam int CLK_PERIOD = 5;

   typedef enum logic [1:0] {
      PS_HOLD = 2'b00,
      PS_INC  = 2'b01,
      PS_JR   = 2'b10,
      PS_BR   = 2'b11
   } pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational next-PC selection
module pc_next_mux
   import mycpu_pkg::*;
#(
   parameter int WIDTH      = mycpu_pkg::WIDTH,
   parameter int OFFSET_MSB = 7
) (
   input  logic [1:0]       ps_in,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [WIDTH-1:0] ins_in,
   input  logic [WIDTH-1:0] ra_in,
   output logic [WIDTH-1:0] pc_next
);

   logic [WIDTH-1:0] offset;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] pc_br;
   logic             ins_hi_unused;

   // Only the low offset field of the instruction matters here.
   assign ins_hi_unused = ^ins_in[WIDTH-1:OFFSET_MSB+1];

   assign offset = {{(WIDTH-OFFSET_MSB-1){ins_in[OFFSET_MSB]}}, ins_in[OFFSET_MSB:0]};
   assign pc_inc = pc_in + WIDTH'(1);
   assign pc_br  = pc_inc + offset;

   always_comb begin
      pc_next = pc_in;
      // Unknown or undefined selects fall through to hold.
      case (ps_in)
         PS_INC:  pc_next = pc_inc;
         PS_JR:   pc_next = ra_in;
         PS_BR:   pc_next = pc_br;
         default: pc_next = pc_in;
      endcase
   end

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - 16-bit PC register with async reset
module program_counter
   import mycpu_pkg::*;
#(
   parameter int               WIDTH       = mycpu_pkg::WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               OFFSET_MSB  = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       ps_in,
   input  logic [WIDTH-1:0] ins_in,
   input  logic [WIDTH-1:0] ra_in,
   output logic [WIDTH-1:0] pc_out
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;

   pc_next_mux #(
      .WIDTH      (WIDTH),
      .OFFSET_MSB (OFFSET_MSB)
   ) u_next (
      .ps_in   (ps_in),
      .pc_in   (pc_q),
      .ins_in  (ins_in),
      .ra_in   (ra_in),
      .pc_next (pc_d)
   );

   // rst_n is active-high despite its name.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pc_q <= RESET_VALUE;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed self-checking bench for program_counter
module tb_program_counter;
   import mycpu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [1:0]  ps_in;
   logic [15:0] ins_in;
   logic [15:0] ra_in;
   logic [15:0] pc_out;

   int tests;
   int fails;

   program_counter dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ps_in  (ps_in),
      .ins_in (ins_in),
      .ra_in  (ra_in),
      .pc_out (pc_out)
   );

   initial clk = 1'b0;
   always #(CLK_PERIOD) clk = ~clk;

   task automatic cyc(input logic [1:0] ps, input logic [15:0] ins, input logic [15:0] ra);
      ps_in  = ps;
      ins_in = ins;
      ra_in  = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc(2'b01, 16'h0000, 16'h0000);
         tests++;
         if (pc_out !== 16'h0000) begin
            $display("FAIL reset_hold[%0d] got %h want 0000", i, pc_out);
            fails++;
         end
      end
      rst_n = 1'b0;
      cyc(2'b01, 16'h0000, 16'h0000);
      tests++;
      if (pc_out !== 16'h0001) begin
         $display("FAIL reset_release got %h want 0001", pc_out);
         fails++;
      end
   endtask

   task automatic test_hold_inc();
      logic [15:0] exp_inc [2];
      exp_inc[0] = 16'h0011;
      exp_inc[1] = 16'h0012;
      cyc(2'b10, 16'h0000, 16'h0010);
      tests++;
      if (pc_out !== 16'h0010) begin
         $display("FAIL jr_setup got %h want 0010", pc_out);
         fails++;
      end
      for (int i = 0; i < 3; i++) begin
         cyc(2'b00, 16'hFFFF, 16'hFFFF);
         tests++;
         if (pc_out !== 16'h0010) begin
            $display("FAIL hold[%0d] got %h want 0010", i, pc_out);
            fails++;
         end
      end
      for (int i = 0; i < 2; i++) begin
         cyc(2'b01, 16'h0000, 16'h0000);
         tests++;
         if (pc_out !== exp_inc[i]) begin
            $display("FAIL inc[%0d] got %h want %h", i, pc_out, exp_inc[i]);
            fails++;
         end
      end
   endtask

   task automatic test_jr();
      cyc(2'b10, 16'h0000, 16'hABCD);
      tests++;
      if (pc_out !== 16'hABCD) begin
         $display("FAIL jr got %h want abcd", pc_out);
         fails++;
      end
   endtask

   task automatic test_branch();
      cyc(2'b10, 16'h0000, 16'h0020);
      cyc(2'b11, 16'h0005, 16'h0000);
      tests++;
      if (pc_out !== 16'h0026) begin
         $display("FAIL branch_fwd got %h want 0026", pc_out);
         fails++;
      end
      // Upper instruction bits set to confirm they are ignored.
      cyc(2'b11, 16'h12FA, 16'h0000);
      tests++;
      if (pc_out !== 16'h0021) begin
         $display("FAIL branch_back got %h want 0021", pc_out);
         fails++;
      end
   endtask

   task automatic test_wrap();
      cyc(2'b10, 16'h0000, 16'hFFFF);
      tests++;
      if (pc_out !== 16'hFFFF) begin
         $display("FAIL wrap_jr got %h want ffff", pc_out);
         fails++;
      end
      cyc(2'b01, 16'h0000, 16'h0000);
      tests++;
      if (pc_out !== 16'h0000) begin
         $display("FAIL wrap_inc got %h want 0000", pc_out);
         fails++;
      end
      cyc(2'b10, 16'h0000, 16'hFFFE);
      cyc(2'b11, 16'h0001, 16'h0000);
      tests++;
      if (pc_out !== 16'h0000) begin
         $display("FAIL wrap_branch got %h want 0000", pc_out);
         fails++;
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  ps  [4];
      logic [15:0] ins [4];
      logic [15:0] exp [4];
      ps[0] = 2'b10; ins[0] = 16'h0000; exp[0] = 16'h0100;
      ps[1] = 2'b11; ins[1] = 16'h0080; exp[1] = 16'h0081;
      ps[2] = 2'b01; ins[2] = 16'h0000; exp[2] = 16'h0082;
      ps[3] = 2'b11; ins[3] = 16'h007F; exp[3] = 16'h0102;
      for (int i = 0; i < 4; i++) begin
         cyc(ps[i], ins[i], 16'h0100);
         tests++;
         if (pc_out !== exp[i]) begin
            $display("FAIL b2b[%0d] got %h want %h", i, pc_out, exp[i]);
            fails++;
         end
      end
   endtask

   task automatic test_async_reset();
      cyc(2'b10, 16'h0000, 16'h1234);
      tests++;
      if (pc_out !== 16'h1234) begin
         $display("FAIL async_setup got %h want 1234", pc_out);
         fails++;
      end
      ps_in = 2'b01;
      #2;
      rst_n = 1'b1;
      #1;
      tests++;
      if (pc_out !== 16'h0000) begin
         $display("FAIL async_assert got %h want 0000", pc_out);
         fails++;
      end
      cyc(2'b01, 16'h0000, 16'h0000);
      tests++;
      if (pc_out !== 16'h0000) begin
         $display("FAIL async_held got %h want 0000", pc_out);
         fails++;
      end
      rst_n = 1'b0;
      cyc(2'bxx, 16'h0000, 16'h5555);
      tests++;
      if (pc_out !== 16'h0000) begin
         $display("FAIL x_hold_after_release got %h want 0000", pc_out);
         fails++;
      end
      cyc(2'b01, 16'h0000, 16'h0000);
      cyc(2'bxx, 16'h00FF, 16'h5555);
      tests++;
      if (pc_out !== 16'h0001) begin
         $display("FAIL x_hold got %h want 0001", pc_out);
         fails++;
      end
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      rst_n  = 1'b1;
      ps_in  = 2'b01;
      ins_in = '0;
      ra_in  = '0;
      #1;
      tests++;
      if (pc_out !== 16'h0000) begin
         $display("FAIL reset_initial got %h want 0000", pc_out);
         fails++;
      end
      test_reset();
      test_hold_inc();
      test_jr();
      test_branch();
      test_wrap();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 16-bit program counter register for the 16-bit RISC CPU.
- Each clock edge it selects the next instruction address from one of four sources: hold, increment, relative branch, or register jump.
- The source is chosen by the 2-bit PC-select code `ps_in` from the control unit.
- `pc_out` drives the instruction-memory address. The block is purely sequential state plus a next-PC mux and adders.

Parameters:
- WIDTH, 16, address/data width of PC, instruction and register inputs.
- RESET_VALUE, 16'h0000, PC value loaded on reset.
- OFFSET_MSB, 7, MSB index of the branch offset field in `ins_in` (field is `ins_in[OFFSET_MSB:0]`).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-high (asserted when 1), despite the codebase port name.
- ps_in  input  2  PC-select code (see Behaviour).
- ins_in  input  WIDTH  current instruction word; low field carries the branch offset.
- ra_in  input  WIDTH  register-file operand A; the jump-register target.
- pc_out  output  WIDTH  current PC; driven directly from the PC register, no combinational path from inputs.

Behaviour:
- Reset:
  - rst_n=1 forces PC=RESET_VALUE immediately, without waiting for a clock edge.
  - PC stays at RESET_VALUE while rst_n=1.
  - First update happens on the first rising clk edge after rst_n returns to 0.
- Next-PC selection, evaluated and registered on the rising clk edge:
  - ps_in=2'b00 (PS_HOLD): PC unchanged.
  - ps_in=2'b01 (PS_INC): PC <= PC + 1 (word addressed).
  - ps_in=2'b10 (PS_JR): PC <= ra_in.
  - ps_in=2'b11 (PS_BR): PC <= PC + 1 + sign_extend(ins_in[OFFSET_MSB:0]).
- Arithmetic:
  - All sums are modulo 2^WIDTH, so wrap-around is silent (16'hFFFF + 1 = 16'h0000).
  - Branch offset is two's complement; sign bit is ins_in[OFFSET_MSB].
- Latency: one cycle; the new PC appears on pc_out after the edge that samples ps_in.
- ps_in containing X/Z, or any undefined code, is treated as PS_HOLD.
- Reset mid-operation: an asynchronous assert overrides any pending selection in the same cycle.
- No handshake and no enable beyond ps_in; inputs are sampled only at the clock edge.

Decomposition:
- Shared package mycpu_pkg, included via mycpu.svh, holds:
  - typedef enum logic [1:0] pc_sel_t {PS_HOLD, PS_INC, PS_JR, PS_BR};
  - constant CLK_PERIOD, the half-period used by benches;
  - WIDTH default as a package constant shared with the datapath.
- One sub-module is natural: pc_next_mux, a combinational next-PC computation (incrementer, sign-extend, branch adder, 4:1 mux). The register and async reset stay in program_counter.
- The test program is a separate program/module pc_test using the same port list.

Test Plan:
- Reset: hold rst_n=1 for two cycles with ps_in=01 -> pc_out stays 16'h0000; after release plus one edge with ps_in=01 -> pc_out=16'h0001.
- Hold/increment: from PC=16'h0010, ps_in=00 for 3 edges -> 16'h0010; then ps_in=01 for 2 edges -> 16'h0012.
- Jump register: PC=16'h0012, ra_in=16'hABCD, ps_in=10 -> pc_out=16'hABCD next cycle.
- Branch both directions:
  - PC=16'h0020, ins_in[7:0]=8'h05, ps_in=11 -> 16'h0026.
  - Then ins_in[7:0]=8'hFA (-6), ps_in=11 -> 16'h0021.
- Wrap-around: ra_in=16'hFFFF, ps_in=10, then ps_in=01 -> pc_out 16'hFFFF then 16'h0000; branch from 16'hFFFE with offset 8'h01 -> 16'h0000.
- Async reset mid-run: PC=16'h1234, assert rst_n=1 between clock edges -> pc_out=16'h0000 before the next edge; ps_in=2'bxx after release -> PC holds.
